pin_irq_arbiter: RTL and testbench

PIN_IRQ_ARBITER -- requirements
Module: pin_irq_arbiter

---
 rtl/pin_irq_pkg.sv | 33 +++
 rtl/pin_irq_pick.sv | 41 ++++
 rtl/pin_irq_arbiter.sv | 150 +++++++++++++++
 tb/tb_pin_irq_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_irq_pkg.sv
// pin_irq_pkg: shared constants, FSM state encoding and index helpers for the
// GPIO pin interrupt arbiter (pin_irq_arbiter, pin_irq_pick).
package pin_irq_pkg;

  // Default arbitrated pin count and pin-ID width.
  localparam int NUM_PINS = 24;
  localparam int ID_W     = 5;

  // Maximum number of cycles spent waiting for the pin mux to drop the flag.
  localparam int DRAIN_CYCLES = 3;

  // Service sequence for one interrupt.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_DRAIN   = 2'd3
  } irq_state_t;

  // (a + b) mod n, valid for a < n and b < n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

  // (a + 1) mod n: the index following a, with n-1 followed by 0.
  function automatic int wrap_inc(input int a, input int n);
    return wrap_add(a, 1, n);
  endfunction

endpackage

// File: rtl/pin_irq_pick.sv
// pin_irq_pick: combinational priority pick over the eligible pins.
// With rr_en=1 the search starts at 'pointer' and wraps modulo NUM_PINS;
// with rr_en=0 the search starts at index 0 (lowest index wins).
module pin_irq_pick #(
  parameter int NUM_PINS = pin_irq_pkg::NUM_PINS,
  parameter int ID_W     = pin_irq_pkg::ID_W
) (
  input  logic [NUM_PINS-1:0] eligible,
  input  logic [ID_W-1:0]     pointer,
  input  logic                rr_en,
  output logic [ID_W-1:0]     winner,
  output logic                found
);
  import pin_irq_pkg::*;

  logic [ID_W-1:0]     base;
  logic [ID_W-1:0]     rot_idx [NUM_PINS];
  logic [NUM_PINS-1:0] rot;

  assign base = rr_en ? pointer : '0;

  // Rotate the request vector so that position 0 is the search start.
  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_rot
    assign rot_idx[gi] = ID_W'(wrap_add(int'(base), gi, NUM_PINS));
    assign rot[gi]     = eligible[rot_idx[gi]];
  end

  // First set bit of the rotated vector; scanning downward lets the lowest
  // rotated position overwrite any later one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        winner = rot_idx[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pin_irq_arbiter.sv
// pin_irq_arbiter: arbitrates latched per-pin GPIO interrupt flags into a
// single ID presented to the CPU, then pulses the matching clear line back to
// the pin mux and waits for the flag to drop before arbitrating again.
// Optional feature: define PIN_IRQ_RR_EN for round-robin selection; otherwise
// the lowest eligible pin wins and no pointer register exists.
module pin_irq_arbiter #(
  parameter int NUM_PINS = pin_irq_pkg::NUM_PINS,
  parameter int ID_W     = pin_irq_pkg::ID_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_PINS-1:0] INTR,
  input  logic [NUM_PINS-1:0] IRQ_MASK,
  output logic [NUM_PINS-1:0] IRQRES,
  output logic                IRQ_VALID,
  output logic [ID_W-1:0]     IRQ_ID,
  input  logic                IRQ_ACK,
  output logic                IRQ_ANY
);
  import pin_irq_pkg::*;

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  logic [NUM_PINS-1:0] eligible;
  logic [ID_W-1:0]     pick_winner;
  logic                pick_found;
  logic [ID_W-1:0]     pointer;
  logic                rr_en;
  logic                id_pin_pending;

  irq_state_t          state_reg;
  logic                valid_reg;
  logic [ID_W-1:0]     id_reg;
  logic [NUM_PINS-1:0] irqres_reg;
  logic                any_reg;
  logic [1:0]          drain_cnt_reg;

  logic                rst_meta_reg;
  logic                rst_sync_reg;

  assign eligible       = INTR & ~IRQ_MASK;
  assign id_pin_pending = INTR[id_reg];

  // Reset is asserted asynchronously but released through two flops, so the
  // edge that sees RST_N rise still holds the logic in its reset state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end

`ifdef PIN_IRQ_RR_EN
  logic [ID_W-1:0] ptr_reg;

  // Round-robin pointer moves past the served pin as the clear pulse starts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_reg <= '0;
    end else if (!rst_sync_reg) begin
      ptr_reg <= '0;
    end else if (state_reg == ST_PRESENT && IRQ_ACK) begin
      ptr_reg <= ID_W'(wrap_inc(int'(id_reg), NUM_PINS));
    end
  end

  assign pointer = ptr_reg;
  assign rr_en   = 1'b1;
`else
  assign pointer = '0;
  assign rr_en   = 1'b0;
`endif

  pin_irq_pick #(
    .NUM_PINS (NUM_PINS),
    .ID_W     (ID_W)
  ) u_pick (
    .eligible (eligible),
    .pointer  (pointer),
    .rr_en    (rr_en),
    .winner   (pick_winner),
    .found    (pick_found)
  );

  // Service FSM with registered outputs: present, clear on accept, drain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      valid_reg     <= 1'b0;
      id_reg        <= '0;
      irqres_reg    <= '0;
      any_reg       <= 1'b0;
      drain_cnt_reg <= '0;
    end else if (!rst_sync_reg) begin
      state_reg     <= ST_IDLE;
      valid_reg     <= 1'b0;
      id_reg        <= '0;
      irqres_reg    <= '0;
      any_reg       <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      any_reg <= |eligible;
      case (state_reg)
        ST_IDLE: begin
          irqres_reg <= '0;
          if (pick_found) begin
            id_reg    <= pick_winner;
            valid_reg <= 1'b1;
            state_reg <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // ID is frozen here; masking or a dropped flag does not withdraw it.
          if (IRQ_ACK) begin
            valid_reg  <= 1'b0;
            irqres_reg <= NUM_PINS'(1) << id_reg;
            state_reg  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          irqres_reg    <= '0;
          drain_cnt_reg <= '0;
          state_reg     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!id_pin_pending || drain_cnt_reg == DRAIN_LAST) begin
            drain_cnt_reg <= '0;
            state_reg     <= ST_IDLE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 2'd1;
          end
        end
        default: begin
          valid_reg  <= 1'b0;
          irqres_reg <= '0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign IRQ_VALID = valid_reg;
  assign IRQ_ID    = id_reg;
  assign IRQRES    = irqres_reg;
  assign IRQ_ANY   = any_reg;

endmodule

// File: tb/tb_pin_irq_arbiter.sv
// tb_pin_irq_arbiter: directed bench for pin_irq_arbiter with a small pin-mux
// model (flags set by the bench, cleared by IRQRES, set wins on collision).
module tb_pin_irq_arbiter;

  localparam int NP = 24;
  localparam int IW = 5;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NP-1:0] INTR;
  logic [NP-1:0] IRQ_MASK;
  logic [NP-1:0] IRQRES;
  logic          IRQ_VALID;
  logic [IW-1:0] IRQ_ID;
  logic          IRQ_ACK;
  logic          IRQ_ANY;

  logic [NP-1:0] set_req;
  logic [NP-1:0] intr_q = '0;

  int checks = 0;
  int passes = 0;

  pin_irq_arbiter #(.NUM_PINS(NP), .ID_W(IW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INTR      (INTR),
    .IRQ_MASK  (IRQ_MASK),
    .IRQRES    (IRQRES),
    .IRQ_VALID (IRQ_VALID),
    .IRQ_ID    (IRQ_ID),
    .IRQ_ACK   (IRQ_ACK),
    .IRQ_ANY   (IRQ_ANY)
  );

  always #5 CLK = ~CLK;

  // Pin mux model: latched flags, cleared by IRQRES, independent of RST_N.
  always @(posedge CLK) intr_q <= (intr_q & ~IRQRES) | set_req;
  assign INTR = intr_q;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Flags appear one edge later; the DUT sees them on the following edge.
  task automatic raise(input logic [NP-1:0] bits);
    set_req = bits;
    tick();
    set_req = '0;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int n);
    n  = 0;
    ok = IRQ_VALID;
    while (!ok && n < budget) begin
      tick();
      n++;
      ok = IRQ_VALID;
    end
  endtask

  task automatic ack(output logic [NP-1:0] res, output logic v_after);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    res     = IRQRES;
    v_after = IRQ_VALID;
  endtask

  task automatic settle;
    repeat (6) tick();
  endtask

  task automatic test_reset;
    RST_N = 1'b0; IRQ_ACK = 1'b0; IRQ_MASK = '0; set_req = '0;
    repeat (3) tick();
    raise(NP'(1) << 2);
    tick();
    checks++; if (IRQ_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", IRQ_VALID); else passes++;
    checks++; if (IRQ_ID !== '0) $display("FAIL rst_id: got %0d want 0", IRQ_ID); else passes++;
    checks++; if (IRQRES !== '0) $display("FAIL rst_irqres: got %h want 0", IRQRES); else passes++;
    checks++; if (IRQ_ANY !== 1'b0) $display("FAIL rst_any: got %b want 0", IRQ_ANY); else passes++;
    RST_N = 1'b1;
    tick();
    checks++; if (IRQ_VALID !== 1'b0 || IRQ_ANY !== 1'b0) $display("FAIL rst_release_edge: valid=%b any=%b want 0 0", IRQ_VALID, IRQ_ANY); else passes++;
    tick();
    checks++; if (IRQ_VALID !== 1'b0) $display("FAIL rst_release_sync: got %b want 0", IRQ_VALID); else passes++;
    tick();
    checks++; if (IRQ_VALID !== 1'b1 || IRQ_ID !== IW'(2)) $display("FAIL rst_first_present: valid=%b id=%0d want 1 2", IRQ_VALID, IRQ_ID); else passes++;
    begin
      logic [NP-1:0] res; logic v;
      ack(res, v);
      $display("reset test: serviced pin %0d irqres=%h", 2, res);
    end
    settle();
  endtask

  task automatic test_single_pin;
    logic [NP-1:0] res;
    logic v;
    raise(NP'(1) << 5);
    checks++; if (IRQ_VALID !== 1'b0) $display("FAIL single_pre: got %b want 0", IRQ_VALID); else passes++;
    tick();
    checks++; if (IRQ_VALID !== 1'b1 || IRQ_ID !== IW'(5)) $display("FAIL single_present: valid=%b id=%0d want 1 5", IRQ_VALID, IRQ_ID); else passes++;
    checks++; if (IRQ_ANY !== 1'b1) $display("FAIL single_any: got %b want 1", IRQ_ANY); else passes++;
    IRQ_MASK = NP'(1) << 5;
    repeat (3) tick();
    checks++; if (IRQ_VALID !== 1'b1 || IRQ_ID !== IW'(5)) $display("FAIL single_hold_masked: valid=%b id=%0d want 1 5", IRQ_VALID, IRQ_ID); else passes++;
    ack(res, v);
    IRQ_MASK = '0;
    checks++; if (res !== (NP'(1) << 5)) $display("FAIL single_irqres: got %h want %h", res, NP'(1) << 5); else passes++;
    checks++; if (v !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", v); else passes++;
    tick();
    checks++; if (IRQRES !== '0) $display("FAIL single_pulse_width: got %h want 0", IRQRES); else passes++;
    tick(); tick();
    checks++; if (IRQ_VALID !== 1'b0 || IRQ_ANY !== 1'b0) $display("FAIL single_idle: valid=%b any=%b want 0 0", IRQ_VALID, IRQ_ANY); else passes++;
    $display("single pin: serviced pin 5 irqres=%h", res);
    settle();
  endtask

  task automatic test_mask;
    logic [NP-1:0] res;
    logic v;
    bit ok;
    int n;
    IRQ_MASK = NP'(1) << 7;
    raise(NP'(1) << 7);
    repeat (4) tick();
    checks++; if (IRQ_VALID !== 1'b0) $display("FAIL mask_valid: got %b want 0", IRQ_VALID); else passes++;
    checks++; if (IRQ_ANY !== 1'b0) $display("FAIL mask_any: got %b want 0", IRQ_ANY); else passes++;
    IRQ_MASK = '0;
    tick();
    checks++; if (IRQ_VALID !== 1'b1 || IRQ_ID !== IW'(7)) $display("FAIL mask_unmask_present: valid=%b id=%0d want 1 7", IRQ_VALID, IRQ_ID); else passes++;
    checks++; if (IRQ_ANY !== 1'b1) $display("FAIL mask_unmask_any: got %b want 1", IRQ_ANY); else passes++;
    ack(res, v);
    checks++; if (res !== (NP'(1) << 7)) $display("FAIL mask_irqres: got %h want %h", res, NP'(1) << 7); else passes++;
    $display("mask: serviced pin 7 irqres=%h", res);
    wait_valid(4, ok, n);
    checks++; if (ok) $display("FAIL mask_no_repeat: got valid id=%0d want idle", IRQ_ID); else passes++;
    settle();
  endtask

  task automatic test_two_pins;
    int exp_ids [3];
    logic [NP-1:0] res;
    logic v;
    bit ok;
    int n;
`ifdef PIN_IRQ_RR_EN
    exp_ids = '{3, 20, 3};
`else
    exp_ids = '{3, 3, 20};
`endif
    // Fresh reset so the round-robin pointer starts at 0.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    raise((NP'(1) << 3) | (NP'(1) << 20));
    for (int k = 0; k < 3; k++) begin
      wait_valid(10, ok, n);
      checks++; if (!ok) $display("FAIL two_timeout[%0d]: no IRQ_VALID within 10 cycles", k); else passes++;
      checks++; if (IRQ_ID !== IW'(exp_ids[k])) $display("FAIL two_order[%0d]: got %0d want %0d", k, IRQ_ID, exp_ids[k]); else passes++;
      ack(res, v);
      checks++; if (res !== (NP'(1) << exp_ids[k])) $display("FAIL two_irqres[%0d]: got %h want %h", k, res, NP'(1) << exp_ids[k]); else passes++;
      $display("two pins: service %0d pin %0d irqres=%h", k, IRQ_ID, res);
      if (k == 0) begin
        tick();
        raise(NP'(1) << 3);
      end
    end
    settle();
  endtask

  task automatic test_wrap;
    logic [NP-1:0] res;
    logic v;
    bit ok;
    int n;
    raise(NP'(1) << 23);
    wait_valid(6, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(23)) $display("FAIL wrap_23: ok=%b id=%0d want 1 23", ok, IRQ_ID); else passes++;
    ack(res, v);
    $display("wrap: serviced pin 23 irqres=%h", res);
    settle();
    raise(NP'(1) | (NP'(1) << 22));
    wait_valid(6, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(0)) $display("FAIL wrap_pick0: ok=%b id=%0d want 1 0", ok, IRQ_ID); else passes++;
    ack(res, v);
    $display("wrap: serviced pin 0 irqres=%h", res);
    wait_valid(8, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(22)) $display("FAIL wrap_pick22: ok=%b id=%0d want 1 22", ok, IRQ_ID); else passes++;
    ack(res, v);
    $display("wrap: serviced pin 22 irqres=%h", res);
    settle();
  endtask

  task automatic test_back_to_back;
    logic [NP-1:0] res;
    logic v;
    bit ok;
    int n;
    raise((NP'(1) << 1) | (NP'(1) << 2));
    wait_valid(6, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(1)) $display("FAIL b2b_first: ok=%b id=%0d want 1 1", ok, IRQ_ID); else passes++;
    ack(res, v);
    wait_valid(10, ok, n);
    // n counts edges after the accepting edge until IRQ_VALID is seen high.
    checks++; if (!ok || n > 4) $display("FAIL b2b_latency: ok=%b cycles=%0d want <=4", ok, n); else passes++;
    checks++; if (IRQ_ID !== IW'(2)) $display("FAIL b2b_second: got %0d want 2", IRQ_ID); else passes++;
    $display("back to back: pin 1 then pin 2 after %0d cycles", n);
    ack(res, v);
    settle();
  endtask

  task automatic test_ack_coincide;
    bit ok;
    int n;
    logic [NP-1:0] res;
    logic v;
    raise(NP'(1) << 9);
    wait_valid(6, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(9)) $display("FAIL coin_first: ok=%b id=%0d want 1 9", ok, IRQ_ID); else passes++;
    IRQ_ACK = 1'b1;
    set_req = NP'(1) << 10;
    tick();
    IRQ_ACK = 1'b0;
    set_req = '0;
    checks++; if (IRQRES !== (NP'(1) << 9)) $display("FAIL coin_irqres: got %h want %h", IRQRES, NP'(1) << 9); else passes++;
    wait_valid(10, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(10)) $display("FAIL coin_new_pin: ok=%b id=%0d want 1 10", ok, IRQ_ID); else passes++;
    $display("ack coincide: pin 9 then pin 10");
    ack(res, v);
    settle();
  endtask

  task automatic test_ack_ignored;
    logic [NP-1:0] seen;
    seen = '0;
    IRQ_ACK = 1'b1;
    repeat (4) begin
      tick();
      seen |= IRQRES;
    end
    IRQ_ACK = 1'b0;
    checks++; if (seen !== '0 || IRQ_VALID !== 1'b0) $display("FAIL ack_idle: irqres=%h valid=%b want 0 0", seen, IRQ_VALID); else passes++;
    $display("ack ignored in idle: irqres=%h", seen);
  endtask

  task automatic test_reset_abort;
    bit ok;
    int n;
    logic [NP-1:0] seen;
    logic [NP-1:0] res;
    logic v;
    raise(NP'(1) << 12);
    wait_valid(6, ok, n);
    checks++; if (!ok || IRQ_ID !== IW'(12)) $display("FAIL abort_present: ok=%b id=%0d want 1 12", ok, IRQ_ID); else passes++;
    RST_N   = 1'b0;
    IRQ_ACK = 1'b1;
    #1;
    checks++; if (IRQ_VALID !== 1'b0 || IRQ_ID !== '0 || IRQRES !== '0) $display("FAIL abort_immediate: valid=%b id=%0d irqres=%h want 0 0 0", IRQ_VALID, IRQ_ID, IRQRES); else passes++;
    seen = '0;
    repeat (3) begin
      tick();
      seen |= IRQRES;
    end
    IRQ_ACK = 1'b0;
    RST_N   = 1'b1;
    wait_valid(10, ok, n);
    seen |= IRQRES;
    checks++; if (seen !== '0) $display("FAIL abort_no_pulse: got %h want 0", seen); else passes++;
    checks++; if (!ok || IRQ_ID !== IW'(12)) $display("FAIL abort_represent: ok=%b id=%0d want 1 12", ok, IRQ_ID); else passes++;
    ack(res, v);
    $display("reset abort: pin 12 re-presented, irqres=%h", res);
    settle();
  endtask

  initial begin
    set_req = '0;
    IRQ_ACK = 1'b0;
    IRQ_MASK = '0;
    RST_N = 1'b0;
    test_reset();
    test_single_pin();
    test_mask();
    test_two_pins();
    test_wrap();
    test_back_to_back();
    test_ack_coincide();
    test_ack_ignored();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
